// File: rtl/spi_router_pkg.sv
// Shared types and helpers for the multi-port SPI router master.
package spi_router_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StGap   = 3'd4
  } state_e;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A requested length of 0, or anything wider than the data path, means a full-width frame.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned data_w);
    if (len == 0 || len > data_w) begin
      return data_w;
    end
    return len;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one tick every CLK_DIV cycles, restarted while clr is high.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Down-count to zero, then reload; clr holds the counter at the start of a half-period.
  always_comb begin
    if (clr || cnt_q == '0) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == '0);

endmodule

// File: rtl/spi_router_master.sv
// SPI master with one shift engine fanned out to NUM_SLAVES independent ports.
// Each command selects its own port, frame length and SPI mode.
module spi_router_master
  import spi_router_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int unsigned LEN_W      = $clog2(DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic [SEL_W-1:0]      cmd_sel,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_cpol,
  input  logic                  cmd_cpha,
  output logic [NUM_SLAVES-1:0] sclk,
  output logic [NUM_SLAVES-1:0] mosi,
  output logic [NUM_SLAVES-1:0] ss_n,
  input  logic [NUM_SLAVES-1:0] miso,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  cmd_drop
);

  localparam int unsigned HcntW = LEN_W + 1;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_W-1:0]     tx_q, tx_d;
  logic [DATA_W-1:0]     rx_sh_q, rx_sh_d;
  logic [HcntW-1:0]      hcnt_q, hcnt_d;
  logic                  sclk_q, sclk_d;
  logic [NUM_SLAVES-1:0] idle_pol_q, idle_pol_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cmd_drop_q, cmd_drop_d;
  logic [NUM_SLAVES-1:0] miso_s1_q, miso_s2_q;

  logic                  tick;
  logic                  sel_ok;
  logic [LEN_W-1:0]      len_eff;
  logic [31:0]           shamt;
  logic                  leading;
  logic                  sample_on_lead;
  logic                  shift_on_lead;
  logic [HcntW-1:0]      hcnt_last;
  logic                  miso_bit;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  frame_on;
  logic [NUM_SLAVES-1:0] drive_oh;
  logic [NUM_SLAVES-1:0] clk_oh;

  // The tick counter sits in reset throughout IDLE so SETUP always gets a full half-period.
  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == StIdle),
    .tick  (tick)
  );

  assign sel_ok  = 32'(cmd_sel) < NUM_SLAVES;
  assign len_eff = LEN_W'(clamp_len(32'(cmd_len), DATA_W));
  // Left-align the right-justified word so the frame MSB always sits at tx_q[DATA_W-1].
  assign shamt   = DATA_W - 32'(len_eff);

  // Even half-period index ends on a leading edge.
  assign leading        = !hcnt_q[0];
  assign sample_on_lead = (mode_q == SPI_MODE0) || (mode_q == SPI_MODE2);
  assign shift_on_lead  = (mode_q == SPI_MODE1) || (mode_q == SPI_MODE3);
  assign hcnt_last      = {len_q, 1'b0} - HcntW'(1);
  assign miso_bit       = miso_s2_q[sel_q];

  // Frame sequencer and shift engine next-state.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    mode_d     = mode_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    hcnt_d     = hcnt_q;
    sclk_d     = sclk_q;
    idle_pol_d = idle_pol_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cmd_drop_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (sel_ok) begin
            state_d             = StSetup;
            sel_d               = cmd_sel;
            len_d               = len_eff;
            mode_d              = {cmd_cpol, cmd_cpha};
            tx_d                = cmd_data << shamt;
            rx_sh_d             = '0;
            hcnt_d              = '0;
            sclk_d              = cmd_cpol;
            idle_pol_d[cmd_sel] = cmd_cpol;
          end else begin
            cmd_drop_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (leading == sample_on_lead) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_bit};
          end
          // In CPHA=1 the first leading edge presents the MSB already on the line.
          if (shift_on_lead ? (leading && hcnt_q != '0) : !leading) begin
            tx_d = tx_q << 1;
          end
          if (hcnt_q == hcnt_last) begin
            state_d = StHold;
          end else begin
            hcnt_d = hcnt_q + HcntW'(1);
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          state_d    = StIdle;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A command arriving mid-frame is discarded without touching the frame.
    if (cmd_valid && state_q != StIdle) begin
      cmd_drop_d = 1'b1;
    end
  end

  // Sequencer and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      len_q      <= '0;
      mode_q     <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      hcnt_q     <= '0;
      sclk_q     <= 1'b0;
      idle_pol_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cmd_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      hcnt_q     <= hcnt_d;
      sclk_q     <= sclk_d;
      idle_pol_q <= idle_pol_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cmd_drop_q <= cmd_drop_d;
    end
  end

  // Two-flop synchroniser on every miso input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= '0;
      miso_s2_q <= '0;
    end else begin
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // One-hot decode of the latched target port.
  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  // Outputs decode straight from registered state, so reset releases ss_n asynchronously.
  assign frame_on = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
  assign drive_oh = sel_oh & {NUM_SLAVES{frame_on}};
  assign clk_oh   = sel_oh & {NUM_SLAVES{state_q == StShift}};

  assign ss_n = ~drive_oh;
  assign mosi = drive_oh & {NUM_SLAVES{tx_q[DATA_W-1]}};
  assign sclk = (clk_oh & {NUM_SLAVES{sclk_q}}) | (~clk_oh & idle_pol_q);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = !cmd_ready;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign cmd_drop  = cmd_drop_q;

endmodule

// File: tb/tb_spi_router_master.sv
// Randomised and directed bench for spi_router_master with a behavioural SPI slave model.
module tb_spi_router_master;

  localparam int NUM_SLAVES = 5;
  localparam int DATA_W     = 16;
  localparam int CLK_DIV    = 4;
  localparam int SEL_W      = 3;
  localparam int LEN_W      = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_W-1:0]     cmd_data;
  logic [SEL_W-1:0]      cmd_sel;
  logic [LEN_W-1:0]      cmd_len;
  logic                  cmd_cpol;
  logic                  cmd_cpha;
  logic [NUM_SLAVES-1:0] sclk;
  logic [NUM_SLAVES-1:0] mosi;
  logic [NUM_SLAVES-1:0] ss_n;
  logic [NUM_SLAVES-1:0] miso;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  cmd_drop;

  spi_router_master #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .cmd_cpol  (cmd_cpol),
    .cmd_cpha  (cmd_cpha),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .cmd_drop  (cmd_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active-frame description shared with the slave model and monitors.
  int                    act_sel = 0;
  int                    act_len = 16;
  bit                    act_cpol = 1'b0;
  bit                    act_cpha = 1'b0;
  logic [15:0]           slave_word = '0;
  bit                    loopback = 1'b0;
  logic [NUM_SLAVES-1:0] exp_pol = '0;
  logic [NUM_SLAVES-1:0] slave_miso = '0;

  assign miso = loopback ? mosi : slave_miso;

  int rxv_cnt  = 0;
  int drop_cnt = 0;
  int bad_idle = 0;
  int exp_rxv  = 0;

  // Slave model state.
  bit          prev_ss = 1'b1;
  bit          prev_sc = 1'b0;
  bit          sv_sc, sv_ss, sv_lead, sv_sample;
  int          bitk = 0;
  int          rises = 0;
  logic [31:0] mosi_acc = '0;
  int          mosi_cnt = 0;

  function automatic logic wbit(input logic [15:0] w, input int idx);
    if (idx < 0 || idx > 15) return 1'b0;
    return w[idx];
  endfunction

  // Behavioural slave: reacts to SCLK edges of the active port according to its mode.
  always @(negedge clk) begin
    sv_sc = sclk[act_sel];
    sv_ss = ss_n[act_sel];
    if (!sv_ss) begin
      if (prev_ss) begin
        bitk     = 0;
        rises    = 0;
        mosi_acc = '0;
        mosi_cnt = 0;
        if (!act_cpha) slave_miso[act_sel] = wbit(slave_word, act_len - 1);
      end else if (sv_sc != prev_sc) begin
        sv_lead   = (sv_sc != act_cpol);
        sv_sample = act_cpha ? !sv_lead : sv_lead;
        if (sv_sc) rises++;
        if (sv_sample) begin
          mosi_acc = (mosi_acc << 1) | 32'(mosi[act_sel]);
          mosi_cnt++;
        end
        if (act_cpha && sv_lead) begin
          slave_miso[act_sel] = wbit(slave_word, act_len - 1 - bitk);
          bitk++;
        end
        if (!act_cpha && !sv_lead) begin
          bitk++;
          slave_miso[act_sel] = wbit(slave_word, act_len - 1 - bitk);
        end
      end
    end
    prev_ss = sv_ss;
    prev_sc = sv_sc;
  end

  // Pulse counters and idle-port watchdog.
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (cmd_drop) drop_cnt++;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i != act_sel) begin
        if (!ss_n[i] || mosi[i] || sclk[i] !== exp_pol[i]) bad_idle++;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one frame and check it against the reference model.
  task automatic run_frame(input int sel, input int len, input bit cpol, input bit cpha,
                           input logic [15:0] data, input logic [15:0] word, input bit lb,
                           input int inject_at);
    int          leff, cyc, exp_lat, drops0, bad0;
    logic [15:0] mask;
    logic [15:0] exp_rx;
    bit          done;
    leff    = (len == 0 || len > DATA_W) ? DATA_W : len;
    mask    = 16'((32'h1 << leff) - 1);
    exp_lat = (2 * leff + 3) * CLK_DIV + 1;
    exp_rx  = (lb ? data : word) & mask;
    wait_ready();
    act_sel      = sel;
    act_len      = leff;
    act_cpol     = cpol;
    act_cpha     = cpha;
    slave_word   = word;
    loopback     = lb;
    exp_pol[sel] = cpol;
    drops0       = drop_cnt;
    bad0         = bad_idle;
    cmd_data     = data;
    cmd_sel      = SEL_W'(sel);
    cmd_len      = LEN_W'(len);
    cmd_cpol     = cpol;
    cmd_cpha     = cpha;
    cmd_valid    = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        check_eq("ss_fall", 32'(ss_n[sel]), 32'd0);
        check_eq("mosi_msb", 32'(mosi[sel]), 32'(data[leff-1]));
        check_eq("busy", 32'(busy), 32'd1);
      end
      if (inject_at != 0 && cyc == inject_at) begin
        cmd_valid = 1'b1;
        cmd_data  = ~data;
        cmd_sel   = SEL_W'((sel + 1) % NUM_SLAVES);
        cmd_len   = LEN_W'(3);
      end else if (inject_at != 0 && cyc == inject_at + 1) begin
        cmd_valid = 1'b0;
      end
      if (rx_valid) done = 1'b1;
    end
    exp_rxv++;
    check_eq("rx_valid_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("rx_data", 32'(rx_data), 32'(exp_rx));
    check_eq("cmd_ready_with_rx", 32'(cmd_ready), 32'd1);
    check_eq("sclk_rises", 32'(rises), 32'(leff));
    check_eq("mosi_bits", mosi_acc, 32'(data & mask));
    check_eq("mosi_cnt", 32'(mosi_cnt), 32'(leff));
    check_eq("ss_released", 32'(ss_n[sel]), 32'd1);
    check_eq("idle_ports", 32'(bad_idle - bad0), 32'd0);
    check_eq("drop_cnt", 32'(drop_cnt - drops0), 32'(inject_at != 0));
  endtask

  initial begin
    int drops0, rxv0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_sel   = '0;
    cmd_len   = '0;
    cmd_cpol  = 1'b0;
    cmd_cpha  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ss_n", 32'(ss_n), 32'h1f);
    check_eq("rst_sclk", 32'(sclk), 32'h0);
    check_eq("rst_mosi", 32'(mosi), 32'h0);
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_cmd_drop", 32'(cmd_drop), 32'h0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, port 1, loopback.
    run_frame(1, 16, 1'b0, 1'b0, 16'hA5C3, 16'h0000, 1'b1, 0);

    // Mode 3, port 0, slave returns 0xABC; SCLK must idle high between frames.
    run_frame(0, 12, 1'b1, 1'b1, 16'h00F0, 16'h0ABC, 1'b0, 0);
    check_eq("mode3_idle_sclk", 32'(sclk[0]), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("mode3_pre_frame_sclk", 32'(sclk[0]), 32'd1);
    run_frame(0, 12, 1'b1, 1'b1, 16'h0123, 16'h0555, 1'b0, 0);

    // Length clamping.
    run_frame(2, 0, 1'b0, 1'b1, 16'h3C5A, 16'hBEEF, 1'b0, 0);
    run_frame(4, 20, 1'b1, 1'b0, 16'hF00D, 16'h1234, 1'b0, 0);

    // Out-of-range select is dropped without any port activity.
    wait_ready();
    drops0    = drop_cnt;
    cmd_sel   = SEL_W'(7);
    cmd_len   = LEN_W'(8);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("bad_sel_busy", 32'(busy), 32'd0);
    check_eq("bad_sel_ss_n", 32'(ss_n), 32'h1f);
    repeat (3) @(negedge clk);
    check_eq("bad_sel_drop", 32'(drop_cnt - drops0), 32'd1);
    check_eq("bad_sel_ready", 32'(cmd_ready), 32'd1);

    // Command during a frame is dropped; frame completes.
    run_frame(3, 10, 1'b0, 1'b1, 16'h02D7, 16'h0199, 1'b0, 30);

    // Randomised frames, some back-to-back.
    for (int k = 0; k < 10; k++) begin
      run_frame(int'($urandom_range(0, NUM_SLAVES - 1)), int'($urandom_range(0, 20)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                16'($urandom), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset around bit 5 of a frame.
    wait_ready();
    act_sel    = 3;
    act_len    = 16;
    act_cpol   = 1'b0;
    act_cpha   = 1'b1;
    loopback   = 1'b0;
    exp_pol[3] = 1'b0;
    cmd_sel    = SEL_W'(3);
    cmd_len    = LEN_W'(16);
    cmd_cpol   = 1'b0;
    cmd_cpha   = 1'b1;
    cmd_data   = 16'h5A5A;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (CLK_DIV + 10 * CLK_DIV - 1) @(negedge clk);
    check_eq("mid_frame_ss", 32'(ss_n[3]), 32'd0);
    rxv0 = rxv_cnt;
    #1;
    rst_n   = 1'b0;
    exp_pol = '0;
    #1;
    check_eq("async_rst_ss_n", 32'(ss_n), 32'h1f);
    check_eq("async_rst_sclk", 32'(sclk), 32'h0);
    check_eq("async_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("no_rx_after_rst", 32'(rxv_cnt - rxv0), 32'd0);
    run_frame(3, 9, 1'b1, 1'b0, 16'h01A6, 16'h0133, 1'b0, 0);

    repeat (3) @(negedge clk);
    check_eq("rx_valid_pulses", 32'(rxv_cnt), 32'(exp_rxv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
